spine_uplink_tx: RTL and testbench
==================================

Name: spine_uplink_tx

Overview:
- Leaf-side transmitter that drives one leaf input port of a spine router (the spineXY_in_data / spineXY_in_valid pair).
- Accepts a packet request from the local leaf logic: destination plus payload length.
- Builds a header flit, streams the payload flits, and optionally adds a checksum tail flit.
- Paces all output with credit-based flow control that mirrors the spine port input FIFO depth.

Parameters:
- GROUP_ID, 4'b1000, source group placed in the header.
- LEAF_ID, 0, source leaf index (2 bits) placed in the header.
- DWIDTH, 16, flit width. Header layout requires DWIDTH ≥ 16.
- FIFO_DEPTH, 8, initial and maximum credits; equals the spine port input FIFO depth.
- CW, $clog2(FIFO_DEPTH+1), credit counter width (derived; do not override).

Ports:
- clk, input, 1: sole clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- req_valid, input, 1: packet request valid.
- req_ready, output, 1: high only in IDLE.
- req_dest, input, 6: destination address {group[3:0], leaf[1:0]}.
- req_len, input, 4: payload flit count. Legal range is 1..8.
- pl_data, input, DWIDTH: payload flit.
- pl_valid, input, 1: payload flit valid.
- pl_ready, output, 1: payload accept.
- spine_in_data, output, DWIDTH: flit to the spine router leaf port.
- spine_in_valid, output, 1: flit valid, one cycle per flit.
- credit_return, input, 1: single-cycle pulse; the spine freed one FIFO slot.
- credit_count, output, CW: credits currently available.
- busy, output, 1: state is not IDLE.
- len_err, output, 1: one-cycle pulse on an illegal request.

Behaviour:

Reset (reset=0, asynchronous):
- state=IDLE, credit_count=FIFO_DEPTH.
- spine_in_data=0, spine_in_valid=0, len_err=0.
- Latched dest/len and flit counter cleared.
- Reset mid-packet abandons the packet. No partial tail is emitted.

Header flit format:
- [15] = 1
- [14:9] = dest
- [8:5] = GROUP_ID
- [4:3] = LEAF_ID
- [2:0] = req_len-1
- Bits above 15 are 0.

FSM states: IDLE, HDR, PAY, TAIL (TAIL is present only with the optional feature).
- IDLE:
  - req_ready=1.
  - On req_valid with req_len in 1..8: latch dest/len, go to HDR.
  - On req_valid with req_len of 0 or >8: pulse len_err next cycle, stay in IDLE, drop the request.
- HDR:
  - If credit_count>0: register the header onto spine_in_data with spine_in_valid=1 (visible next cycle), consume one credit, go to PAY.
  - Otherwise hold in HDR with spine_in_valid=0.
- PAY:
  - pl_ready = (credit_count>0). This is combinational from state and credits only.
  - On pl_valid&pl_ready: register pl_data onto the output next cycle, consume one credit, increment the flit counter.
  - After the last flit (counter==len): go to IDLE, or to TAIL if the optional feature is enabled.
  - A bubble (pl_valid=0) produces spine_in_valid=0 that cycle. The packet is not aborted.

Output timing:
- spine_in_valid is registered and deasserts in any cycle where no flit is sent.
- Back-to-back packets are legal. The minimum gap is one idle cycle, spent in IDLE accepting the next request.

Credits:
- Next credit_count = credit_count + credit_return − sent.
- Simultaneous return and send leaves the count unchanged.
- Returns at credit_count==FIFO_DEPTH are ignored (saturate).
- No flit is ever sent at credit_count==0.

Latency:
- Request accept to header on the output: 2 cycles, given credits.
- Payload handshake to flit on the output: 1 cycle.

Optional Feature:
Macro: SPINE_UPLINK_CHKSUM_EN

With the macro defined:
- After the last payload flit, the FSM enters TAIL.
- TAIL emits one flit equal to the XOR of the header and all payload flits. It needs a credit and waits in TAIL if none is available.
- The header length field is unchanged; the receiver knows a tail follows.

Without the macro:
- The TAIL state and the XOR accumulator are absent.
- PAY goes directly to IDLE after the last flit.

Test Plan:
1. Reset, then a request with dest=6'b0101_10, len=3, and payload 0xAAAA, 0x5555, 0x1234 offered continuously:
   - Outputs 0x8000|(0x16<<9)|(GROUP_ID<<5)|(LEAF_ID<<3)|2, then the three payload flits, on consecutive cycles.
   - credit_count goes 8→4 (8→3 with the checksum; tail flit = header^0xAAAA^0x5555^0x1234).
2. No credit returns; issue two len=8 packets:
   - First packet uses 9 credits, but only 8 exist. The header plus 7 payload flits are sent, then pl_ready=0 and output stalls at credit_count=0.
   - One credit_return pulse releases exactly one flit.
3. credit_return asserted in the same cycle as a flit send at credit_count=5 → credit_count stays 5. A return at credit_count=8 with nothing in flight → stays 8.
4. req_len=0 and, separately, req_len=9:
   - len_err pulses for one cycle, req_ready stays 1, and no flit appears.
   - A following legal request is serviced normally.
5. pl_valid toggles 1,0,1 during a len=2 packet → output valid pattern 1(hdr),1,0,1, and busy drops the cycle after the last flit.
6. reset asserted while in PAY after 2 of 5 payload flits:
   - Outputs clear immediately and credit_count=8.
   - After release, a new len=1 packet emits its header and one payload flit.

Source files
------------

// File: rtl/spine_uplink_tx.sv
`default_nettype none
// ============================================================================
// Module   : spine_uplink_tx
// Brief    : Leaf-side packet transmitter into one spine router leaf port with
//            credit-based pacing; SPINE_UPLINK_CHKSUM_EN adds an XOR tail flit.
// Revision : 1.0 - initial release
// ============================================================================
module spine_uplink_tx #(
    parameter logic [3:0] GROUP_ID   = 4'b1000,
    parameter logic [1:0] LEAF_ID    = 2'd0,
    parameter int         DWIDTH     = 16,
    parameter int         FIFO_DEPTH = 8,
    parameter int         CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_dest,
    input  logic [3:0]        req_len,
    input  logic [DWIDTH-1:0] pl_data,
    input  logic              pl_valid,
    output logic              pl_ready,
    output logic [DWIDTH-1:0] spine_in_data,
    output logic              spine_in_valid,
    input  logic              credit_return,
    output logic [CW-1:0]     credit_count,
    output logic              busy,
    output logic              len_err
);

`ifdef SPINE_UPLINK_CHKSUM_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_HDR = 2'd1, S_PAY = 2'd2, S_TAIL = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_HDR = 2'd1, S_PAY = 2'd2} state_t;
`endif

    localparam logic [CW-1:0] c_credit_max = CW'(FIFO_DEPTH);

    state_t            r_state;
    logic [CW-1:0]     r_credit;
    logic [DWIDTH-1:0] r_data;
    logic              r_valid;
    logic              r_len_err;
    logic [5:0]        r_dest;
    logic [2:0]        r_last_idx;   // requested length minus one
    logic [2:0]        r_cnt;
`ifdef SPINE_UPLINK_CHKSUM_EN
    logic [DWIDTH-1:0] r_acc;
`endif

    logic              w_has_credit;
    logic              w_pay_hs;
    logic              w_send;
    logic              w_ret;
    logic              w_len_ok;
    logic [CW-1:0]     w_credit_next;
    logic [DWIDTH-1:0] w_header;

    always_comb begin
        w_has_credit = (r_credit != '0);
        w_pay_hs     = (r_state == S_PAY) && pl_valid && w_has_credit;
        w_send       = w_has_credit && (r_state != S_IDLE) && ((r_state != S_PAY) || pl_valid);
        // A return while already full has no matching flit in flight.
        w_ret        = credit_return && (r_credit != c_credit_max);
        w_credit_next = r_credit + {{(CW-1){1'b0}}, w_ret} - {{(CW-1){1'b0}}, w_send};
        w_len_ok     = (req_len != 4'd0) && (req_len <= 4'd8);
        w_header       = '0;
        w_header[15:0] = {1'b1, r_dest, GROUP_ID, LEAF_ID, r_last_idx};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_credit   <= c_credit_max;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_len_err  <= 1'b0;
            r_dest     <= '0;
            r_last_idx <= '0;
            r_cnt      <= '0;
`ifdef SPINE_UPLINK_CHKSUM_EN
            r_acc      <= '0;
`endif
        end else begin
            r_credit  <= w_credit_next;
            r_valid   <= w_send;
            r_len_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (w_len_ok) begin
                            r_dest     <= req_dest;
                            r_last_idx <= req_len[2:0] - 3'd1;
                            r_cnt      <= '0;
                            r_state    <= S_HDR;
                        end else begin
                            r_len_err  <= 1'b1;
                        end
                    end
                end
                S_HDR: begin
                    if (w_has_credit) begin
                        r_data  <= w_header;
`ifdef SPINE_UPLINK_CHKSUM_EN
                        r_acc   <= w_header;
`endif
                        r_state <= S_PAY;
                    end
                end
                S_PAY: begin
                    if (w_pay_hs) begin
                        r_data <= pl_data;
                        r_cnt  <= r_cnt + 3'd1;
`ifdef SPINE_UPLINK_CHKSUM_EN
                        r_acc  <= r_acc ^ pl_data;
                        if (r_cnt == r_last_idx) r_state <= S_TAIL;
`else
                        if (r_cnt == r_last_idx) r_state <= S_IDLE;
`endif
                    end
                end
`ifdef SPINE_UPLINK_CHKSUM_EN
                S_TAIL: begin
                    if (w_has_credit) begin
                        r_data  <= r_acc;
                        r_state <= S_IDLE;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready      = (r_state == S_IDLE);
    assign busy           = (r_state != S_IDLE);
    assign pl_ready       = (r_state == S_PAY) && w_has_credit;
    assign spine_in_data  = r_data;
    assign spine_in_valid = r_valid;
    assign credit_count   = r_credit;
    assign len_err        = r_len_err;

endmodule
`default_nettype wire

// File: tb/tb_spine_uplink_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_spine_uplink_tx
// Brief    : Self-checking bench for spine_uplink_tx: vector table, directed
//            corner sequences and a randomized run against a flit-queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spine_uplink_tx;

    localparam int         DW    = 16;
    localparam int         DEPTH = 8;
    localparam logic [3:0] GID   = 4'b1000;
    localparam logic [1:0] LID   = 2'd0;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready;
    logic [5:0]    req_dest;
    logic [3:0]    req_len;
    logic [DW-1:0] pl_data;
    logic          pl_valid, pl_ready;
    logic [DW-1:0] spine_in_data;
    logic          spine_in_valid;
    logic          credit_return;
    logic [3:0]    credit_count;
    logic          busy, len_err;

    spine_uplink_tx dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dest(req_dest), .req_len(req_len),
        .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
        .spine_in_data(spine_in_data), .spine_in_valid(spine_in_valid),
        .credit_return(credit_return), .credit_count(credit_count),
        .busy(busy), .len_err(len_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0]  dest;
        logic [3:0]  len;
        logic [15:0] exp_hdr;
        logic        exp_err;
    } vec_t;

    vec_t        vecs[8];
    logic [15:0] pay[8];
    logic [15:0] exp_q[$];
    logic [15:0] hp;
    logic [3:0]  rlen;
    logic [5:0]  rdest;
    int          in_flight, idx, plen;
    bit          active, hs, ret, err_exp;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] hdr_of(input logic [5:0] d, input logic [3:0] l);
        logic [3:0] lm1;
        lm1 = l - 4'd1;
        return 16'h8000 | (16'(d) << 9) | (16'(GID) << 5) | (16'(LID) << 3) | 16'(lm1 & 4'd7);
    endfunction

    task automatic drain();
        int n;
        n = 0;
        while (!(credit_count == 4'(DEPTH) && !busy) && n < 40) begin
            credit_return = (credit_count < 4'(DEPTH));
            tick();
            n++;
        end
        credit_return = 1'b0;
        chk("drain_credits", credit_count, DEPTH);
    endtask

    task automatic run_pkt(input logic [5:0] dest, input logic [3:0] len, input logic [15:0] exp_hdr);
        logic [15:0] x;
        int n;
        chk("req_ready_idle", req_ready, 1);
        req_dest = dest; req_len = len; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        chk("hdr_valid", spine_in_valid, 1);
        chk("hdr_data", spine_in_data, exp_hdr);
        x = exp_hdr;
        n = 1;
        for (int i = 0; i < int'(len); i++) begin
            pl_valid = 1'b1; pl_data = pay[i];
            tick();
            chk("pay_valid", spine_in_valid, 1);
            chk("pay_data", spine_in_data, pay[i]);
            x ^= pay[i];
            n++;
        end
        pl_valid = 1'b0; pl_data = '0;
`ifdef SPINE_UPLINK_CHKSUM_EN
        tick();
        chk("tail_valid", spine_in_valid, 1);
        chk("tail_data", spine_in_data, x);
        n++;
`endif
        chk("credits_after_pkt", credit_count, DEPTH - n);
        drain();
    endtask

    initial begin
        vecs[0] = '{6'h16, 4'd3, 16'hAD02, 1'b0};
        vecs[1] = '{6'h3F, 4'd1, 16'hFF00, 1'b0};
        vecs[2] = '{6'h16, 4'd0, 16'h0000, 1'b1};
        vecs[3] = '{6'h00, 4'd6, 16'h8105, 1'b0};
        vecs[4] = '{6'h05, 4'd9, 16'h0000, 1'b1};
        vecs[5] = '{6'h21, 4'd5, 16'hC304, 1'b0};
        vecs[6] = '{6'h11, 4'd15, 16'h0000, 1'b1};
        vecs[7] = '{6'h2A, 4'd2, 16'hD501, 1'b0};

        reset = 1'b0; req_valid = 1'b0; req_dest = '0; req_len = '0;
        pl_data = '0; pl_valid = 1'b0; credit_return = 1'b0;
        tick(); tick();
        chk("rst_credit", credit_count, DEPTH);
        chk("rst_valid", spine_in_valid, 0);
        chk("rst_data", spine_in_data, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_pl_ready", pl_ready, 0);
        reset = 1'b1;
        tick();

        // Vector table: header format, payload streaming and illegal lengths
        for (int v = 0; v < 8; v++) begin
            if (v == 0) begin
                pay[0] = 16'hAAAA; pay[1] = 16'h5555; pay[2] = 16'h1234;
            end else begin
                for (int i = 0; i < 8; i++) pay[i] = 16'($urandom);
            end
            if (!vecs[v].exp_err) begin
                run_pkt(vecs[v].dest, vecs[v].len, vecs[v].exp_hdr);
            end else begin
                req_dest = vecs[v].dest; req_len = vecs[v].len; req_valid = 1'b1;
                tick();
                req_valid = 1'b0;
                chk("err_pulse", len_err, 1);
                chk("err_req_ready", req_ready, 1);
                chk("err_no_flit", spine_in_valid, 0);
                tick();
                chk("err_pulse_end", len_err, 0);
                chk("err_no_flit2", spine_in_valid, 0);
                tick();
                chk("err_no_flit3", spine_in_valid, 0);
                chk("err_credit", credit_count, DEPTH);
            end
        end

        // Credit exhaustion on a len=8 packet; one return releases one flit
        for (int i = 0; i < 8; i++) pay[i] = 16'h0F00 + 16'(i);
        req_dest = 6'h09; req_len = 4'd8; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        chk("exh_hdr", spine_in_data, hdr_of(6'h09, 4'd8));
        pl_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            pl_data = pay[i];
            tick();
            chk("exh_pay", spine_in_data, pay[i]);
            chk("exh_pay_valid", spine_in_valid, 1);
        end
        pl_data = pay[7];
        chk("exh_credit0", credit_count, 0);
        chk("exh_pl_ready0", pl_ready, 0);
        tick();
        chk("exh_stall1", spine_in_valid, 0);
        tick();
        chk("exh_stall2", spine_in_valid, 0);
        credit_return = 1'b1;
        tick();
        credit_return = 1'b0;
        chk("exh_ret_credit", credit_count, 1);
        chk("exh_ret_no_flit", spine_in_valid, 0);
        chk("exh_pl_ready1", pl_ready, 1);
        tick();
        chk("exh_last_valid", spine_in_valid, 1);
        chk("exh_last_data", spine_in_data, pay[7]);
        chk("exh_credit_end", credit_count, 0);
        pl_valid = 1'b0;
        tick();
        chk("exh_only_one", spine_in_valid, 0);
        drain();

        // Simultaneous return and send at credit 5; saturating return at full
        for (int i = 0; i < 4; i++) pay[i] = 16'h7700 + 16'(i);
        req_dest = 6'h01; req_len = 4'd4; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        pl_valid = 1'b1;
        pl_data = pay[0]; tick();
        pl_data = pay[1]; tick();
        chk("sim_credit5", credit_count, 5);
        pl_data = pay[2]; credit_return = 1'b1;
        tick();
        credit_return = 1'b0;
        chk("sim_credit_hold", credit_count, 5);
        chk("sim_sent", spine_in_data, pay[2]);
        pl_data = pay[3];
        tick();
        chk("sim_credit4", credit_count, 4);
        pl_valid = 1'b0;
`ifdef SPINE_UPLINK_CHKSUM_EN
        tick();
`endif
        drain();
        credit_return = 1'b1;
        tick();
        credit_return = 1'b0;
        chk("sat_credit", credit_count, DEPTH);

        // Bubble inside a len=2 packet
        req_dest = 6'h30; req_len = 4'd2; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        chk("bub_hdr_v", spine_in_valid, 1);
        pl_valid = 1'b1; pl_data = 16'hBEEF;
        tick();
        chk("bub_p0_v", spine_in_valid, 1);
        chk("bub_p0_d", spine_in_data, 16'hBEEF);
        pl_valid = 1'b0; pl_data = 16'hDEAD;
        tick();
        chk("bub_gap_v", spine_in_valid, 0);
        chk("bub_gap_busy", busy, 1);
        pl_valid = 1'b1; pl_data = 16'hCAFE;
        tick();
        pl_valid = 1'b0;
        chk("bub_p1_v", spine_in_valid, 1);
        chk("bub_p1_d", spine_in_data, 16'hCAFE);
`ifdef SPINE_UPLINK_CHKSUM_EN
        tick();
        chk("bub_tail", spine_in_data, hdr_of(6'h30, 4'd2) ^ 16'hBEEF ^ 16'hCAFE);
`endif
        chk("bub_busy_drop", busy, 0);
        drain();

        // Asynchronous reset mid-payload
        for (int i = 0; i < 5; i++) pay[i] = 16'h3300 + 16'(i);
        req_dest = 6'h22; req_len = 4'd5; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        pl_valid = 1'b1;
        pl_data = pay[0]; tick();
        pl_data = pay[1]; tick();
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", spine_in_valid, 0);
        chk("arst_data", spine_in_data, 0);
        chk("arst_credit", credit_count, DEPTH);
        chk("arst_busy", busy, 0);
        pl_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("arst_quiet", spine_in_valid, 0);
        pay[0] = 16'h4242;
        run_pkt(6'h0C, 4'd1, hdr_of(6'h0C, 4'd1));

        // Randomized traffic against a flit-queue and credit-ledger model
        in_flight = 0; active = 0; idx = 0; plen = 0;
        for (int cyc = 0; cyc < 3300; cyc++) begin
            req_valid = 1'b0; credit_return = 1'b0; pl_valid = 1'b0;
            pl_data = 16'($urandom);
            err_exp = 0;
            if (cyc < 3000 && !active && req_ready && ($urandom_range(0, 3) == 0)) begin
                rdest = 6'($urandom);
                if ($urandom_range(0, 9) == 0)
                    rlen = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 15));
                else
                    rlen = 4'($urandom_range(1, 8));
                req_valid = 1'b1; req_dest = rdest; req_len = rlen;
                if (rlen >= 4'd1 && rlen <= 4'd8) begin
                    hp = hdr_of(rdest, rlen);
                    exp_q.push_back(hp);
                    for (int i = 0; i < int'(rlen); i++) begin
                        pay[i] = 16'($urandom);
                        exp_q.push_back(pay[i]);
                        hp ^= pay[i];
                    end
`ifdef SPINE_UPLINK_CHKSUM_EN
                    exp_q.push_back(hp);
`endif
                    active = 1; idx = 0; plen = int'(rlen);
                end else begin
                    err_exp = 1;
                end
            end else if (active && idx < plen && $urandom_range(0, 3) != 0) begin
                pl_valid = 1'b1; pl_data = pay[idx];
            end
            if (in_flight > 0 && $urandom_range(0, 2) == 0) credit_return = 1'b1;
            hs  = pl_valid && pl_ready;
            ret = credit_return;
            tick();
            if (hs) idx++;
            if (active && idx == plen) active = 0;
            if (ret) in_flight--;
            if (spine_in_valid) begin
                in_flight++;
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected_flit", spine_in_data, 32'hFFFF_FFFF);
                end else begin
                    chk("rnd_flit", spine_in_data, exp_q.pop_front());
                end
            end
            chk("rnd_credit", credit_count, DEPTH - in_flight);
            chk("rnd_len_err", len_err, err_exp);
        end
        chk("rnd_all_flits_sent", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
